// File: rtl/y86_data_mem_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// data-memory unit (slave).
interface y86_data_mem_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        icode;
  logic [ADDR_W-1:0] valA;
  logic [ADDR_W-1:0] valE;
  logic [63:0]       valP;
  logic              resp_valid;
  logic [63:0]       valM;
  logic              mem_error;

  modport master (
    output req_valid, icode, valA, valE, valP,
    input  req_ready, resp_valid, valM, mem_error
  );

  modport slave (
    input  req_valid, icode, valA, valE, valP,
    output req_ready, resp_valid, valM, mem_error
  );
endinterface

// File: rtl/y86_data_mem_unit.sv
// Y86-64 data-memory stage: byte-addressed little-endian 8-byte accesses,
// bounds-checked, one request outstanding, read data after READ_LAT cycles.
module y86_data_mem_unit #(
  parameter int DEPTH_BYTES = 8192,
  parameter int READ_LAT    = 1,
  parameter int ADDR_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  y86_data_mem_unit_if.slave   bus,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [63:0]          dbg_data
);

  localparam int                AW       = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_BYTES - 8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg;
  logic [63:0]       hold_reg;
  logic [63:0]       valm_reg;
  logic              err_reg;
  logic [63:0]       dbg_reg;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              op_read, op_write, acc_err, accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [63:0]       wdata, acc_rdata, dbg_rdata;
  logic [AW-1:0]     acc_idx, dbg_idx;
  logic              dbg_err;

  // Decode icode into operation, effective address and store data.
  always_comb begin
    op_read  = 1'b0;
    op_write = 1'b0;
    acc_addr = '0;
    wdata    = '0;
    case (bus.icode)
      4'h4: begin op_write = 1'b1; acc_addr = bus.valE; wdata = bus.valA; end
      4'h5: begin op_read  = 1'b1; acc_addr = bus.valE; end
      4'h8: begin op_write = 1'b1; acc_addr = bus.valE; wdata = bus.valP; end
      4'h9: begin op_read  = 1'b1; acc_addr = bus.valA; end
      4'hA: begin op_write = 1'b1; acc_addr = bus.valE; wdata = bus.valA; end
      4'hB: begin op_read  = 1'b1; acc_addr = bus.valA; end
      default: ;
    endcase
  end

  // Full-width unsigned compare so wrap-around addresses are caught too.
  assign acc_err = (op_read | op_write) && (acc_addr > MAX_ADDR);
  assign acc_idx = acc_addr[AW-1:0];
  assign accept  = bus.req_valid && (state_reg == IDLE);
  assign dbg_err = dbg_addr > MAX_ADDR;
  assign dbg_idx = dbg_addr[AW-1:0];

  // Byte lanes for the access port and the debug port; lane gi holds addr+gi.
  // Out-of-range indices only occur when the result is discarded.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign acc_rdata[8*gi +: 8] = mem[acc_idx + AW'(gi)];
      assign dbg_rdata[8*gi +: 8] = mem[dbg_idx + AW'(gi)];
    end
  endgenerate

  // Commit all eight bytes of an in-bounds write on the accept edge.
  always_ff @(posedge clk) begin
    if (accept && op_write && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[acc_idx + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // State register plus latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next == WAIT) begin
        cnt_reg <= 3'(READ_LAT - 1);
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - 3'd1;
      end
    end
  end

  // Next-state logic; errors, writes and NOPs skip the wait phase.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (op_read && !acc_err && (READ_LAT > 1)) state_next = WAIT;
          else                                       state_next = RESP;
        end
      end
      WAIT:    if (cnt_reg == 3'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.req_ready  = (state_reg == IDLE);
    bus.resp_valid = (state_reg == RESP);
  end

  // Read data is captured at acceptance so it reflects memory at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
    end else if (accept && op_read && !acc_err) begin
      hold_reg <= acc_rdata;
    end
  end

  // valM / mem_error only change on entry to RESP and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valm_reg <= '0;
      err_reg  <= 1'b0;
    end else if (state_next == RESP) begin
      if (state_reg == IDLE) begin
        valm_reg <= (op_read && !acc_err) ? acc_rdata : 64'd0;
        err_reg  <= acc_err;
      end else begin
        valm_reg <= hold_reg;
        err_reg  <= 1'b0;
      end
    end
  end

  assign bus.valM      = valm_reg;
  assign bus.mem_error = err_reg;

  // Debug snoop port, independent of the request FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_reg <= '0;
    else        dbg_reg <= dbg_err ? 64'd0 : dbg_rdata;
  end

  assign dbg_data = dbg_reg;

endmodule

// File: doc/y86_data_mem_unit.md
Name: y86_data_mem_unit

Overview:
Parametrised data-memory stage for the Y86-64 core: byte-addressed, little-endian, 8-byte accesses with bounds checking and a valid/ready request handshake. It decodes icode into read/write operations and returns valM after a configurable read latency. It also flags address errors for the status logic (STAT=ADR). It sits between execute (valE, valA, valP) and write-back (valM), and replaces the fixed-depth word-array memory stage.

Parameters:
DEPTH_BYTES, 8192, memory size in bytes; power of two, at least 16
READ_LAT, 1, cycles from request acceptance to resp_valid for reads; legal range 1..4
ADDR_W, 64, width of address operands valA and valE

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present this cycle
req_ready  out  1  unit can accept a request
icode  in  4  instruction code of the request
valA  in  64  store data, or address for ret/popq
valE  in  64  address for rmmovq/mrmovq/call/pushq
valP  in  64  return address stored by call
resp_valid  out  1  one-cycle pulse: request complete
valM  out  64  read data; valid while resp_valid=1
mem_error  out  1  valid while resp_valid=1; access out of bounds
dbg_addr  in  64  debug byte address
dbg_data  out  64  registered 8-byte little-endian read at dbg_addr

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low, single clock domain.
- Reset values: req_ready=1, resp_valid=0, valM=0, mem_error=0, dbg_data=0, FSM=IDLE, latency counter=0. Memory array contents are not reset.
- Operation decode:
  - 0x4 rmmovq: write valA at valE
  - 0x5 mrmovq: read at valE
  - 0x8 call: write valP at valE
  - 0x9 ret: read at valA
  - 0xA pushq: write valA at valE
  - 0xB popq: read at valA
  - any other icode: NOP
- Access format: 8 bytes at addr..addr+7, little-endian (byte addr = bits [7:0]). Unaligned addresses are legal.
- Bounds: error when addr > DEPTH_BYTES-8, using full 64-bit unsigned compare (covers wrap-around). An errored write modifies no byte. An errored read returns valM=0.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE. Acceptance = req_valid && req_ready at posedge.
  - IDLE -> RESP on accept of a write, NOP, or any erroring request. Writes commit all 8 bytes atomically on the accept edge.
  - IDLE -> WAIT on accept of an in-bounds read when READ_LAT>1; the counter loads READ_LAT-1. With READ_LAT=1, a read goes IDLE -> RESP directly.
  - WAIT: counter decrements each cycle; at 1 -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE (req_ready=1 the following cycle).
  - Max throughput is one request per 2 cycles (write/NOP) or READ_LAT+1 cycles (read).
- Read data sampling: read data is captured on the accept edge. A later request cannot alter it, since only one request is outstanding.
- Output hold: valM and mem_error hold their last value outside RESP. Consumers must qualify them with resp_valid. Writes and NOPs drive valM=0.
- Reset mid-operation: the FSM returns to IDLE immediately and no resp_valid pulse is issued. A write accepted before reset stays committed.
- req_valid while busy is ignored. The requester must hold the request until it is accepted.
- Debug port: every cycle, dbg_data <= 8 bytes at dbg_addr. An out-of-bounds dbg_addr gives 0. The debug port has no effect on the FSM.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> outputs go to reset values immediately, without waiting for a clock edge; req_ready=1.
- Write then read, READ_LAT=1:
  - rmmovq valA=0x1122334455667788, valE=0x100 -> resp_valid one cycle after accept, valM=0.
  - mrmovq valE=0x100 -> valM=0x1122334455667788 one cycle after accept.
  - Debug read at 0x100 -> byte 0x88 in dbg_data[7:0].
- Unaligned overlap: pushq valA=0xAAAAAAAAAAAAAAAA at 0x200, then rmmovq valA=0 at 0x204, then popq valA=0x200 -> valM=0x00000000AAAAAAAA.
- Bounds (DEPTH_BYTES=8192):
  - call at valE=0x1FF9 -> mem_error=1, no bytes written.
  - valE=0xFFFFFFFFFFFFFFFC -> mem_error=1 (wrap-around case).
  - valE=0x1FF8 -> mem_error=0.
- READ_LAT=3: ret valA=0x100 -> resp_valid exactly 3 cycles after accept; req_ready low for 3 cycles. A req_valid with a conflicting icode held during WAIT is not accepted.
- Reset in WAIT: accept mrmovq with READ_LAT=4, pulse rst_n low at cycle 2 -> no resp_valid. The next request completes normally.
